// File: rtl/frame_write_arbiter_if.sv
// Handshake and pixel bus between two pixel engines, the frame-write arbiter and the BMP writer port.
interface frame_write_arbiter_if;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       s0_valid;
  logic [7:0] s0_r, s0_g, s0_b;
  logic       s0_ready;
  logic       s1_valid;
  logic [7:0] s1_r, s1_g, s1_b;
  logic       s1_ready;
  logic       frame_abort;
  logic       hsync;
  logic [7:0] DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B;
  logic       busy;
  logic       frame_done;
  logic       frame_src;
  logic       frame_aborted;

  modport master (
    output req, s0_valid, s0_r, s0_g, s0_b, s1_valid, s1_r, s1_g, s1_b, frame_abort,
    input  gnt, s0_ready, s1_ready, hsync, DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B,
           busy, frame_done, frame_src, frame_aborted
  );

  modport slave (
    input  req, s0_valid, s0_r, s0_g, s0_b, s1_valid, s1_r, s1_g, s1_b, frame_abort,
    output gnt, s0_ready, s1_ready, hsync, DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B,
           busy, frame_done, frame_src, frame_aborted
  );
endinterface

// File: rtl/frame_write_arbiter.sv
// Round-robin, frame-granular arbiter sharing one BMP frame-write pixel port between two engines,
// with col/row tracking, optional inter-line blanking and frame completion/abort reporting.
module frame_write_arbiter #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int HBLANK = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  frame_write_arbiter_if.slave  bus
);
  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)    : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT)   : 1;
  localparam int BW = (HBLANK > 0) ? $clog2(HBLANK+1) : 1;
  localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

  typedef enum logic [1:0] {IDLE, XFER, BLANK, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          src_q, src_d;
  logic          last_src_q, last_src_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] blank_cnt_q, blank_cnt_d;
  logic          hsync_q, hsync_d;
  logic [23:0]   pix_q, pix_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_src_q, frame_src_d;
  logic          frame_aborted_q, frame_aborted_d;

  logic        xfer, abort, rdy0, rdy1, beat, pick;
  logic [23:0] sel_pix;

  // Ready is combinational from the registered grant; an abort in the same cycle blocks the beat.
  assign xfer    = (state_q == XFER);
  assign abort   = bus.frame_abort && (state_q == XFER || state_q == BLANK);
  assign rdy0    = xfer && gnt_q[0] && !bus.frame_abort;
  assign rdy1    = xfer && gnt_q[1] && !bus.frame_abort;
  assign beat    = (rdy0 && bus.s0_valid) || (rdy1 && bus.s1_valid);
  assign sel_pix = src_q ? {bus.s1_r, bus.s1_g, bus.s1_b} : {bus.s0_r, bus.s0_g, bus.s0_b};
  assign pick    = (bus.req == 2'b11) ? ~last_src_q : bus.req[1];

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    src_d           = src_q;
    last_src_d      = last_src_q;
    col_d           = col_q;
    row_d           = row_q;
    blank_cnt_d     = blank_cnt_q;
    hsync_d         = beat;
    pix_d           = beat ? sel_pix : pix_q;
    frame_done_d    = 1'b0;
    frame_src_d     = frame_src_q;
    frame_aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          src_d   = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          state_d = XFER;
        end
      end
      XFER: begin
        if (beat) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              state_d = DONE;
            end else begin
              row_d = row_q + RW'(1);
              if (HBLANK > 0) begin
                blank_cnt_d = '0;
                state_d     = BLANK;
              end
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          blank_cnt_d = '0;
          state_d     = XFER;
        end else begin
          blank_cnt_d = blank_cnt_q + BW'(1);
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        frame_src_d  = src_q;
        last_src_d   = src_q;
        gnt_d        = 2'b00;
        col_d        = '0;
        row_d        = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The aborted engine counts as served so the other one wins the next tie.
    if (abort) begin
      state_d         = IDLE;
      gnt_d           = 2'b00;
      col_d           = '0;
      row_d           = '0;
      blank_cnt_d     = '0;
      last_src_d      = src_q;
      frame_aborted_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q         <= IDLE;
      gnt_q           <= 2'b00;
      src_q           <= 1'b0;
      last_src_q      <= 1'b1;
      col_q           <= '0;
      row_q           <= '0;
      blank_cnt_q     <= '0;
      hsync_q         <= 1'b0;
      pix_q           <= '0;
      frame_done_q    <= 1'b0;
      frame_src_q     <= 1'b0;
      frame_aborted_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      src_q           <= src_d;
      last_src_q      <= last_src_d;
      col_q           <= col_d;
      row_q           <= row_d;
      blank_cnt_q     <= blank_cnt_d;
      hsync_q         <= hsync_d;
      pix_q           <= pix_d;
      frame_done_q    <= frame_done_d;
      frame_src_q     <= frame_src_d;
      frame_aborted_q <= frame_aborted_d;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.s0_ready      = rdy0;
  assign bus.s1_ready      = rdy1;
  assign bus.hsync         = hsync_q;
  assign bus.DATA_WRITE_R  = pix_q[23:16];
  assign bus.DATA_WRITE_G  = pix_q[15:8];
  assign bus.DATA_WRITE_B  = pix_q[7:0];
  assign bus.busy          = (state_q != IDLE);
  assign bus.frame_done    = frame_done_q;
  assign bus.frame_src     = frame_src_q;
  assign bus.frame_aborted = frame_aborted_q;
endmodule

// File: tb/tb_frame_write_arbiter.sv
// Directed bench for frame_write_arbiter: a 4x2 frame with no blanking (dut_a) and with
// two blanking cycles per line (dut_b), both fed from the same engine stimulus.
module tb_frame_write_arbiter;
  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic [1:0]  req;
  logic        s0_valid, s1_valid, frame_abort;
  logic [23:0] s0_pix, s1_pix;

  frame_write_arbiter_if ifa();
  frame_write_arbiter_if ifb();

  assign ifa.req = req;                 assign ifb.req = req;
  assign ifa.s0_valid = s0_valid;       assign ifb.s0_valid = s0_valid;
  assign ifa.s1_valid = s1_valid;       assign ifb.s1_valid = s1_valid;
  assign ifa.frame_abort = frame_abort; assign ifb.frame_abort = frame_abort;
  assign ifa.s0_r = s0_pix[23:16];      assign ifb.s0_r = s0_pix[23:16];
  assign ifa.s0_g = s0_pix[15:8];       assign ifb.s0_g = s0_pix[15:8];
  assign ifa.s0_b = s0_pix[7:0];        assign ifb.s0_b = s0_pix[7:0];
  assign ifa.s1_r = s1_pix[23:16];      assign ifb.s1_r = s1_pix[23:16];
  assign ifa.s1_g = s1_pix[15:8];       assign ifb.s1_g = s1_pix[15:8];
  assign ifa.s1_b = s1_pix[7:0];        assign ifb.s1_b = s1_pix[7:0];

  frame_write_arbiter #(.WIDTH(4), .HEIGHT(2), .HBLANK(0)) dut_a (.HCLK(HCLK), .HRESETn(HRESETn), .bus(ifa));
  frame_write_arbiter #(.WIDTH(4), .HEIGHT(2), .HBLANK(2)) dut_b (.HCLK(HCLK), .HRESETn(HRESETn), .bus(ifb));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Engine e, pixel i: r = e*64+i, g = r+16, b = r+32.
  function automatic logic [23:0] px(input int e, input int i);
    logic [7:0] b;
    b = 8'(e * 64 + i);
    return {b, b + 8'd16, b + 8'd32};
  endfunction

  typedef struct {
    logic [1:0]  req;
    logic        v0;
    logic [7:0]  p0;
    logic [30:0] exp;  // {gnt, busy, hsync, rgb, frame_done, frame_src, s0_ready}
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic [1:0] rq, input logic v, input int p, input logic [1:0] g,
                              input logic bz, input logic hs, input logic [23:0] rgb,
                              input logic dn, input logic sr, input logic rd);
    vec_t t;
    t.req = rq; t.v0 = v; t.p0 = 8'(p);
    t.exp = {g, bz, hs, rgb, dn, sr, rd};
    return t;
  endfunction

  // Scoreboard state for dut_a.
  int idx0, idx1, beats0, beats1, hs_cnt, ab_cnt, cur;
  int excl_err, hs_err, data_err, hold_err;
  logic [1:0]  prev_gnt;
  logic [23:0] last_rgb;
  logic [1:0]  gnt_log[$];
  logic        src_log[$];
  bit          tog0;

  function automatic logic [23:0] rgb_a();
    return {ifa.DATA_WRITE_R, ifa.DATA_WRITE_G, ifa.DATA_WRITE_B};
  endfunction

  function automatic logic [31:0] outs_a();
    return {ifa.gnt, ifa.busy, ifa.hsync, rgb_a(), ifa.frame_done, ifa.frame_src,
            ifa.frame_aborted, ifa.s0_ready, ifa.s1_ready};
  endfunction

  task automatic do_reset();
    HRESETn = 1'b0;
    req = 2'b00; s0_valid = 1'b0; s1_valid = 1'b0; frame_abort = 1'b0;
    s0_pix = '0; s1_pix = '0; tog0 = 1'b0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    idx0 = 0; idx1 = 0; beats0 = 0; beats1 = 0; hs_cnt = 0; ab_cnt = 0; cur = 0;
    excl_err = 0; hs_err = 0; data_err = 0; hold_err = 0;
    prev_gnt = 2'b00; last_rgb = '0;
    gnt_log.delete(); src_log.delete();
  endtask

  // One clock of dut_a: engines present pixel idx, acceptance follows the ready handshake.
  task automatic cycle_a();
    logic b0, b1;
    logic [23:0] e, rgb;
    s0_pix = px(0, idx0);
    s1_pix = px(1, idx1);
    @(negedge HCLK);
    if ((ifa.s0_ready && ifa.gnt != 2'b01) || (ifa.s1_ready && ifa.gnt != 2'b10)) excl_err++;
    b0 = s0_valid && ifa.s0_ready;
    b1 = s1_valid && ifa.s1_ready;
    e  = b0 ? s0_pix : s1_pix;
    @(posedge HCLK); #1;
    rgb = rgb_a();
    if (ifa.hsync !== (b0 || b1)) hs_err++;
    if (b0 || b1) begin
      if (rgb !== e) data_err++;
    end else if (rgb !== last_rgb) begin
      hold_err++;
    end
    last_rgb = rgb;
    hs_cnt += int'(ifa.hsync);
    if (b0) begin idx0++; beats0++; end
    if (b1) begin idx1++; beats1++; end
    if (ifa.gnt != 2'b00 && prev_gnt == 2'b00) begin
      gnt_log.push_back(ifa.gnt);
      cur = int'(ifa.gnt[1]);
    end
    prev_gnt = ifa.gnt;
    if (ifa.frame_done) begin
      src_log.push_back(ifa.frame_src);
      if (cur == 1) idx1 = 0; else idx0 = 0;
    end
    if (ifa.frame_aborted) begin
      ab_cnt++;
      if (cur == 1) idx1 = 0; else idx0 = 0;
    end
    if (tog0) s0_valid = ~s0_valid;
  endtask

  task automatic run_frames(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (src_log.size() < n && k < budget) begin
      cycle_a();
      k++;
    end
    check({name, "_frames_done"}, 64'(src_log.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] glog;
    logic [2:0] slog;
    int ib, hsb, gap, errb, doneb, k;
    logic pre, srcb;

    do_reset();
    check("reset_outputs", 64'(outs_a()), 64'(0));

    // Single 4x2 frame from engine 0, req dropped after the grant cycle.
    tv.push_back(mk(2'b01, 1, 0, 2'b01, 1, 0, 24'h0,     0, 0, 1));
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(2'b00, 1, i, 2'b01, 1, 1, px(0, i), 0, 0, (i < 7) ? 1'b1 : 1'b0));
    tv.push_back(mk(2'b00, 1, 8, 2'b00, 0, 0, px(0, 7), 1, 0, 0));
    tv.push_back(mk(2'b00, 0, 9, 2'b00, 0, 0, px(0, 7), 0, 0, 0));
    for (int i = 0; i < tv.size(); i++) begin
      req = tv[i].req;
      s0_valid = tv[i].v0;
      s0_pix = px(0, int'(tv[i].p0));
      @(posedge HCLK); #1;
      check($sformatf("vec%0d", i),
            64'({ifa.gnt, ifa.busy, ifa.hsync, rgb_a(), ifa.frame_done, ifa.frame_src, ifa.s0_ready}),
            64'(tv[i].exp));
    end

    // Two blanking cycles between lines on dut_b.
    do_reset();
    req = 2'b01; s0_valid = 1'b1;
    ib = 0; hsb = 0; gap = 0; errb = 0; doneb = 0; k = 0; srcb = 1'b1;
    while (doneb == 0 && k < 60) begin
      s0_pix = px(0, ib);
      @(negedge HCLK);
      pre = ifb.s0_ready;
      if (ib == 4 && !pre) gap++;
      @(posedge HCLK); #1;
      k++;
      req = 2'b00;
      if (ifb.hsync !== pre) errb++;
      if (ifb.hsync) begin
        if ({ifb.DATA_WRITE_R, ifb.DATA_WRITE_G, ifb.DATA_WRITE_B} !== px(0, hsb)) errb++;
        hsb++;
      end
      if (pre) ib++;
      if (ifb.frame_done) begin doneb++; srcb = ifb.frame_src; end
    end
    check("blank_gap", 64'(gap), 64'(2));
    check("blank_hsync_count", 64'(hsb), 64'(8));
    check("blank_stream_errors", 64'(errb), 64'(0));
    check("blank_done", 64'({doneb[1:0], srcb}), 64'({2'd1, 1'b0}));

    // Both engines requesting for three frames: grant alternates.
    do_reset();
    req = 2'b11; s0_valid = 1'b1; s1_valid = 1'b1;
    run_frames("rr", 3, 120);
    glog = '0; slog = '0;
    for (int i = 0; i < gnt_log.size() && i < 3; i++) glog[5-2*i -: 2] = gnt_log[i];
    for (int i = 0; i < src_log.size() && i < 3; i++) slog[2-i] = src_log[i];
    check("rr_grant_order", 64'(glog), 64'(6'b01_10_01));
    check("rr_src_order", 64'(slog), 64'(3'b010));
    check("rr_ready_exclusive", 64'(excl_err), 64'(0));
    check("rr_stream", 64'(hs_err + data_err + hold_err), 64'(0));
    check("rr_hsync_count", 64'(hs_cnt), 64'(24));

    // Engine 0 valid toggling every cycle.
    do_reset();
    req = 2'b01; s0_valid = 1'b1; tog0 = 1'b1;
    run_frames("toggle", 1, 80);
    check("toggle_beats", 64'(beats0), 64'(8));
    check("toggle_hsync_count", 64'(hs_cnt), 64'(8));
    check("toggle_hold", 64'(hold_err), 64'(0));
    check("toggle_stream", 64'(hs_err + data_err), 64'(0));
    check("toggle_src", 64'((src_log.size() > 0) ? src_log[0] : 1'bx), 64'(0));

    // Abort engine 1's frame on beat 5.
    do_reset();
    req = 2'b10; s1_valid = 1'b1;
    k = 0;
    while (idx1 < 4 && k < 40) begin cycle_a(); k++; end
    check("abort_reach_beat5", 64'(idx1), 64'(4));
    frame_abort = 1'b1;
    s1_pix = px(1, 4);
    @(negedge HCLK);
    check("abort_ready_low", 64'(ifa.s1_ready), 64'(0));
    @(posedge HCLK); #1;
    check("abort_outputs", 64'({ifa.hsync, ifa.gnt, ifa.busy, ifa.frame_done, ifa.frame_aborted}),
          64'({1'b0, 2'b00, 1'b0, 1'b0, 1'b1}));
    check("abort_data_held", 64'(rgb_a()), 64'(px(1, 3)));
    frame_abort = 1'b0;
    req = 2'b11;
    @(posedge HCLK); #1;
    check("abort_regrant", 64'({ifa.gnt, ifa.frame_aborted, ifa.frame_done}), 64'({2'b01, 1'b0, 1'b0}));
    check("abort_stream", 64'(hs_err + data_err + hold_err), 64'(0));

    // Asynchronous reset mid-frame, then a clean frame from engine 1.
    do_reset();
    req = 2'b01; s0_valid = 1'b1;
    k = 0;
    while (idx0 < 3 && k < 40) begin cycle_a(); k++; end
    check("rst_reach_beat3", 64'(idx0), 64'(3));
    #2;
    HRESETn = 1'b0;
    #1;
    check("rst_async_outputs", 64'(outs_a()), 64'(0));
    do_reset();
    req = 2'b10; s1_valid = 1'b1;
    run_frames("post_rst", 1, 60);
    check("post_rst_beats", 64'(beats1), 64'(8));
    check("post_rst_hsync_count", 64'(hs_cnt), 64'(8));
    check("post_rst_stream", 64'(hs_err + data_err + hold_err), 64'(0));
    check("post_rst_src", 64'((src_log.size() > 0) ? src_log[0] : 1'bx), 64'(1));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/frame_write_arbiter.md
Name: frame_write_arbiter

Overview:
- Shares the single BMP frame-write datapath (hsync + DATA_WRITE_R/G/B pixel port) between two pixel-producing processing engines.
- Grants the writer to one requester for a whole frame, round-robin between frames.
- Accepts pixels over valid/ready and forwards them one per accepted beat.
- Counts col/row, inserts optional inter-line blanking and reports frame completion with source ID.

Parameters:
- WIDTH, 768, pixels per line.
- HEIGHT, 512, lines per frame.
- HBLANK, 0, idle cycles forced after every line except the last (0 = none).

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- req  in  2  frame request per engine; bit n = engine n.
- gnt  out  2  one-hot grant; at most one bit set.
- s0_valid  in  1  engine 0 pixel valid.
- s0_r, s0_g, s0_b  in  8 each  engine 0 pixel.
- s0_ready  out  1  engine 0 pixel accepted.
- s1_valid, s1_r, s1_g, s1_b, s1_ready  same as engine 0, for engine 1.
- frame_abort  in  1  synchronous abort of the current frame.
- hsync  out  1  pixel strobe to writer.
- DATA_WRITE_R, DATA_WRITE_G, DATA_WRITE_B  out  8 each  pixel to writer.
- busy  out  1  high when state is not IDLE.
- frame_done  out  1  one-cycle pulse after last pixel of a frame.
- frame_src  out  1  engine ID of the frame just completed; valid with frame_done, held until next frame_done.
- frame_aborted  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (async, HRESETn low): all outputs 0; state IDLE; col = row = blank_cnt = 0; last_src = 1, so engine 0 wins the first tie.
- States: IDLE, XFER, BLANK, DONE.
- IDLE:
  - If no req bit is set, stay.
  - If exactly one bit is set, grant it.
  - If both bits are set, grant ~last_src.
  - gnt is registered and asserted in the cycle the state becomes XFER.
- XFER:
  - sN_ready = gnt[N] combinationally; the ungranted ready is always 0.
  - Beat accepted = sN_valid && sN_ready.
  - On beat: hsync = 1 and DATA_WRITE_* = the granted engine's r/g/b, registered, so one cycle latency. Otherwise hsync = 0 and DATA_WRITE_* hold their last value.
  - col advances on each beat. At the beat with col == WIDTH-1: col <= 0.
    - If row == HEIGHT-1: go to DONE.
    - Else if HBLANK > 0: row++ and go to BLANK.
    - Else: row++ and stay in XFER.
- BLANK: ready = 0 and hsync = 0. Count HBLANK cycles, then return to XFER.
- DONE (one cycle):
  - frame_done = 1; frame_src = granted ID; last_src = granted ID.
  - gnt <= 0; row <= 0; go to IDLE.
  - Total frame_done latency: 2 cycles after the last accepted beat; the last hsync occurs 1 cycle before frame_done.
- Grant is held for the whole frame. req deassertion mid-frame is ignored. A new req from the other engine waits until IDLE.
- A requester still asserting req in DONE is re-evaluated in IDLE, so back-to-back frames carry a 1-cycle IDLE gap.
  - If both requesters are set, the grant alternates.
- frame_abort:
  - Honoured in XFER or BLANK. The same-cycle beat is not accepted (ready forced 0 when frame_abort = 1).
  - Next cycle: IDLE, gnt = 0, col = row = 0, frame_aborted pulse, frame_done not pulsed, last_src updated to the aborted ID.
  - Ignored in IDLE and DONE.
- Counters: col is $clog2(WIDTH) bits, row is $clog2(HEIGHT) bits, blank_cnt is $clog2(HBLANK+1) bits. No wrap beyond WIDTH-1 / HEIGHT-1.
- Invalid sN_valid while not granted is ignored; no data from the ungranted engine ever reaches DATA_WRITE_*.

Test Plan:
- WIDTH=4, HEIGHT=2, HBLANK=0; req=01; s0 streams 8 pixels (r=i, g=i+16, b=i+32) with valid always high:
  - gnt=01 one cycle after req.
  - 8 hsync pulses with matching data, contiguous.
  - frame_done at the cycle after the last hsync with frame_src=0; busy falls with gnt.
- Same config, HBLANK=2:
  - After the 4th beat, s0_ready=0 for exactly 2 cycles and no hsync.
  - Beats 5–8 then follow; still 8 hsync total.
- req=11 held continuously for 3 frames:
  - Grant order is 0, 1, 0.
  - frame_src sequence is 0, 1, 0.
  - s1_ready stays 0 during engine 0 frames, and the converse.
- Engine 0 valid toggles 1,0,1,0:
  - hsync count equals accepted beats.
  - DATA_WRITE_* holds between pulses.
  - Frame completes after exactly 8 accepted beats regardless of gaps.
- frame_abort asserted with valid high on beat 5 of engine 1's frame:
  - Beat 5 is not forwarded.
  - frame_aborted pulses, gnt=00, no frame_done.
  - Next req=11 grants engine 0.
- HRESETn pulled low mid-frame at beat 3:
  - All outputs 0 immediately, asynchronously.
  - After release, req=10 yields a full 8-beat frame from engine 1 starting at col 0, row 0.
